// File: rtl/dc_scan.sv
// Digit-scan sequencer for a multiplexed 4-digit display, with per-slot blanking.
// Optional leading-zero blanking of the captured mask when DC_SCAN_LZB_EN is defined.
module dc_scan #(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 1000
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic [15:0] idata,
  input  logic [3:0]  imask,
  output logic [1:0]  oa,
  output logic        os,
  output logic [3:0]  onib,
  output logic        oframe
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_data;
  logic [3:0]    r_mask;
  logic          r_pend;
  logic [1:0]    r_oa;
  logic          r_os;
  logic [3:0]    r_onib;
  logic          r_oframe;

  logic [CW-1:0] w_cnt_nx;
  logic [1:0]    w_idx_nx;
  logic [15:0]   w_data_nx;
  logic [3:0]    w_mask_nx;
  logic [3:0]    w_mask_cap;
  logic [3:0]    w_nib_nx;
  logic          w_wrap;
  logic          w_start;
  logic          w_blank;
  logic          w_os_nx;

`ifdef DC_SCAN_LZB_EN
  logic [3:0] w_lz;
  // Suppress digits above the most significant non-zero nibble; digit 0 always lights.
  assign w_lz       = {|idata[15:12], |idata[15:8], |idata[15:4], 1'b1};
  assign w_mask_cap = imask & w_lz;
`else
  assign w_mask_cap = imask;
`endif

  if (BLANK == 0) begin : g_no_blank
    assign w_blank = 1'b0;
  end else begin : g_blank
    assign w_blank = (w_cnt_nx < CW'(BLANK));
  end

  always_comb begin
    w_wrap    = (r_cnt == LAST);
    w_start   = r_pend | (w_wrap & (r_idx == 2'd3));
    w_cnt_nx  = (w_start | w_wrap) ? '0 : r_cnt + CW'(1);
    w_idx_nx  = w_start ? 2'd0 : (w_wrap ? r_idx + 2'd1 : r_idx);
    w_data_nx = w_start ? idata : r_data;
    w_mask_nx = w_start ? w_mask_cap : r_mask;
    w_nib_nx  = w_data_nx[{w_idx_nx, 2'b00} +: 4];
    w_os_nx   = ~w_blank & w_mask_nx[w_idx_nx];
  end

  // Outputs are registered from next-state values so they align with the slot counter.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_data   <= 16'h0000;
      r_mask   <= 4'h0;
      r_pend   <= 1'b1;
      r_oa     <= 2'd0;
      r_os     <= 1'b0;
      r_onib   <= 4'h0;
      r_oframe <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nx;
      r_idx    <= w_idx_nx;
      r_data   <= w_data_nx;
      r_mask   <= w_mask_nx;
      r_pend   <= 1'b0;
      r_oa     <= w_idx_nx;
      r_os     <= w_os_nx;
      r_onib   <= w_nib_nx;
      r_oframe <= w_start;
    end
  end

  assign oa     = r_oa;
  assign os     = r_os;
  assign onib   = r_onib;
  assign oframe = r_oframe;

endmodule

// File: tb/tb_dc_scan.sv
// Directed self-checking bench for dc_scan with DIV=4; instance u_a uses BLANK=1,
// instance u_b uses BLANK=0. Expected LZB results depend on DC_SCAN_LZB_EN.
module tb_dc_scan;

  logic        iclk;
  logic        irst;
  logic [15:0] data_a, data_b;
  logic [3:0]  mask_a, mask_b;
  logic [1:0]  oa_a, oa_b;
  logic        os_a, os_b;
  logic [3:0]  nib_a, nib_b;
  logic        fr_a, fr_b;

  int n_checks = 0;
  int n_err    = 0;

  dc_scan #(.DIV(4), .BLANK(1)) u_a (
    .iclk(iclk), .irst(irst), .idata(data_a), .imask(mask_a),
    .oa(oa_a), .os(os_a), .onib(nib_a), .oframe(fr_a)
  );

  dc_scan #(.DIV(4), .BLANK(0)) u_b (
    .iclk(iclk), .irst(irst), .idata(data_b), .imask(mask_b),
    .oa(oa_b), .os(os_b), .onib(nib_b), .oframe(fr_b)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Expected {oa, os, onib, oframe} for frame cycle c (0..15) with DIV=4.
  function automatic logic [7:0] exp_vec(input logic [15:0] d, input logic [3:0] m,
                                         input int c, input int blank);
    logic [1:0] s;
    logic [3:0] nib;
    logic       o;
    s   = 2'((c / 4) % 4);
    nib = 4'((d >> (4 * s)) & 16'h000F);
    o   = ((c % 4) >= blank) ? m[s] : 1'b0;
    return {s, o, nib, ((c % 16) == 0)};
  endfunction

  task automatic test_reset();
    irst   = 1'b1;
    data_a = 16'h1234; mask_a = 4'hF;
    data_b = 16'h1234; mask_b = 4'b0101;
    #12;
    n_checks++;
    if ({oa_a, os_a, nib_a, fr_a} !== 8'h00) begin
      n_err++; $display("FAIL reset_a got %h exp 00", {oa_a, os_a, nib_a, fr_a});
    end
    n_checks++;
    if ({oa_b, os_b, nib_b, fr_b} !== 8'h00) begin
      n_err++; $display("FAIL reset_b got %h exp 00", {oa_b, os_b, nib_b, fr_b});
    end
    @(negedge iclk) irst = 1'b0;
    @(negedge iclk);
  endtask

  // Starts and ends at the sample point of a frame's cycle 0.
  task automatic test_scan();
    logic [7:0] e;
    for (int c = 0; c < 16; c++) begin
      e = exp_vec(16'h1234, 4'hF, c, 1);
      n_checks++;
      if ({oa_a, os_a, nib_a, fr_a} !== e) begin
        n_err++; $display("FAIL scan c=%0d got %h exp %h", c, {oa_a, os_a, nib_a, fr_a}, e);
      end
      @(negedge iclk);
    end
  endtask

  task automatic test_mask_noblank();
    logic [7:0] e;
    for (int c = 0; c < 16; c++) begin
      e = exp_vec(16'h1234, 4'b0101, c, 0);
      n_checks++;
      if ({oa_b, os_b, nib_b, fr_b} !== e) begin
        n_err++; $display("FAIL mask c=%0d got %h exp %h", c, {oa_b, os_b, nib_b, fr_b}, e);
      end
      @(negedge iclk);
    end
  endtask

  task automatic test_hold();
    logic [7:0] e;
    for (int c = 0; c < 32; c++) begin
      e = exp_vec((c < 16) ? 16'h1234 : 16'hABCD, 4'hF, c, 1);
      n_checks++;
      if ({oa_a, os_a, nib_a, fr_a} !== e) begin
        n_err++; $display("FAIL hold c=%0d got %h exp %h", c, {oa_a, os_a, nib_a, fr_a}, e);
      end
      if (c == 4) data_a = 16'hABCD;
      @(negedge iclk);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    repeat (9) @(negedge iclk);
    #2 irst = 1'b1;
    #1;
    n_checks++;
    if ({oa_a, os_a, nib_a, fr_a, oa_b, os_b, nib_b, fr_b} !== 16'h0000) begin
      n_err++; $display("FAIL rst_async got %h exp 0000",
                        {oa_a, os_a, nib_a, fr_a, oa_b, os_b, nib_b, fr_b});
    end
    @(negedge iclk) irst = 1'b0;
    @(negedge iclk);
    for (int c = 0; c < 17; c++) begin
      e = exp_vec(16'hABCD, 4'hF, c, 1);
      n_checks++;
      if ({oa_a, os_a, nib_a, fr_a} !== e) begin
        n_err++; $display("FAIL rst_a c=%0d got %h exp %h", c, {oa_a, os_a, nib_a, fr_a}, e);
      end
      e = exp_vec(16'h1234, 4'b0101, c, 0);
      n_checks++;
      if ({oa_b, os_b, nib_b, fr_b} !== e) begin
        n_err++; $display("FAIL rst_b c=%0d got %h exp %h", c, {oa_b, os_b, nib_b, fr_b}, e);
      end
      @(negedge iclk);
    end
  endtask

  task automatic test_lzb(input logic [15:0] d, input logic [3:0] m_exp);
    logic [7:0] e;
    @(negedge iclk) irst = 1'b1;
    data_a = d; mask_a = 4'hF;
    @(negedge iclk) irst = 1'b0;
    @(negedge iclk);
    for (int c = 0; c < 16; c++) begin
      e = exp_vec(d, m_exp, c, 1);
      n_checks++;
      if ({oa_a, os_a, nib_a, fr_a} !== e) begin
        n_err++; $display("FAIL lzb d=%h c=%0d got %h exp %h", d, c,
                          {oa_a, os_a, nib_a, fr_a}, e);
      end
      @(negedge iclk);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_mask_noblank();
    test_hold();
    test_reset_mid();
`ifdef DC_SCAN_LZB_EN
    test_lzb(16'h0050, 4'b0011);
    test_lzb(16'h0000, 4'b0001);
`else
    test_lzb(16'h0050, 4'hF);
    test_lzb(16'h0000, 4'hF);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
